// File: rtl/fifo_access_scheduler_pkg.sv
// Shared types and helpers for the FIFO access scheduler.
// Provides the op encoding and a width helper that never returns zero.
package fifo_sched_pkg;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam int DEFAULT_DW    = 8;
    localparam int DEFAULT_DEPTH = 16;

    // $clog2 clamped to at least 1 so single-bit indices stay legal vectors
    function automatic int clog2_min1(input int v);
        return (v <= 2) ? 1 : $clog2(v);
    endfunction

endpackage

// File: rtl/fifo_access_scheduler_rr_arbiter.sv
// Round-robin arbiter: picks the first asserted request at or after rr_ptr,
// and moves the pointer past the winner when the grant is actually used.
module rr_arbiter
    import fifo_sched_pkg::*;
#(
    parameter int NUM_REQ = 4
)(
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic                           advance,
    output logic [NUM_REQ-1:0]             grant,
    output logic [clog2_min1(NUM_REQ)-1:0] grant_idx
);

    localparam int IW = clog2_min1(NUM_REQ);

    logic [IW-1:0] rr_ptr;
    logic          any;

    // Scan from the far end back toward rr_ptr so the nearest hit wins.
    always_comb begin
        grant_idx = '0;
        any       = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                grant_idx = IW'((int'(rr_ptr) + k) % NUM_REQ);
                any       = 1'b1;
            end
        end
    end

    assign grant = any ? (NUM_REQ'(1) << grant_idx) : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (advance) begin
            rr_ptr <= (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
        end
    end

endmodule

// File: rtl/fifo_access_scheduler.sv
// Front-end for a single-op-per-cycle FIFO: round-robin producers, one reader,
// write/read alternation under contention. Optional macro FIFO_SCHED_WATERMARK_EN.
module fifo_access_scheduler
    import fifo_sched_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int DW        = DEFAULT_DW,
    parameter int DEPTH     = DEFAULT_DEPTH
`ifdef FIFO_SCHED_WATERMARK_EN
    ,
    parameter int AF_THRESH = 12
`endif
)(
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ*DW-1:0]              req_data,
    output logic [NUM_REQ-1:0]                 req_ready,
    input  logic                               rd_req,
    output logic                               rd_valid,
    output logic [DW-1:0]                      rd_data,
    output logic                               fifo_wr,
    output logic                               fifo_rd,
    output logic [DW-1:0]                      fifo_din,
    input  logic [DW-1:0]                      fifo_dout,
    input  logic                               fifo_empty,
    input  logic                               fifo_full,
    output logic [clog2_min1(NUM_REQ)-1:0]     grant_id,
    output logic [clog2_min1(DEPTH+1)-1:0]     occupancy
`ifdef FIFO_SCHED_WATERMARK_EN
    ,
    output logic                               almost_full
`endif
);

    localparam int IW = clog2_min1(NUM_REQ);
    localparam int OW = clog2_min1(DEPTH + 1);

    logic               wr_elig;
    logic               rd_elig;
    logic               prefer_rd;
    logic               do_wr;
    logic               do_rd;
    op_t                last_op;
    logic [NUM_REQ-1:0] arb_grant;
    logic [IW-1:0]      arb_idx;

    assign wr_elig = (|req_valid) && !fifo_full;
    assign rd_elig = rd_req && !fifo_empty;

`ifdef FIFO_SCHED_WATERMARK_EN
    assign almost_full = (occupancy >= OW'(AF_THRESH));
    // Near the top, drain first so producers do not stall on a full FIFO.
    assign prefer_rd   = almost_full || (last_op == OP_WRITE);
`else
    assign prefer_rd   = (last_op == OP_WRITE);
`endif

    // At most one op per cycle; nothing issues while reset is held.
    always_comb begin
        do_wr = 1'b0;
        do_rd = 1'b0;
        if (rst) begin
            if (wr_elig && rd_elig) begin
                do_rd = prefer_rd;
                do_wr = !prefer_rd;
            end else begin
                do_wr = wr_elig;
                do_rd = rd_elig;
            end
        end
    end

    rr_arbiter #(
        .NUM_REQ (NUM_REQ)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       (req_valid),
        .advance   (do_wr),
        .grant     (arb_grant),
        .grant_idx (arb_idx)
    );

    assign fifo_wr   = do_wr;
    assign fifo_rd   = do_rd;
    assign req_ready = do_wr ? arb_grant : '0;
    assign grant_id  = do_wr ? arb_idx : '0;
    assign fifo_din  = do_wr ? req_data[arb_idx*DW +: DW] : '0;
    assign rd_data   = fifo_dout;

    // Shadow count tracks the FIFO exactly since only eligible ops issue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_op   <= OP_READ;
            occupancy <= '0;
            rd_valid  <= 1'b0;
        end else begin
            rd_valid <= do_rd;
            if (do_wr) begin
                last_op   <= OP_WRITE;
                occupancy <= occupancy + OW'(1);
            end else if (do_rd) begin
                last_op   <= OP_READ;
                occupancy <= occupancy - OW'(1);
            end
        end
    end

endmodule

// File: tb/tb_fifo_access_scheduler.sv
// Directed bench for fifo_access_scheduler with a behavioural 16x8 FIFO behind it.
module tb_fifo_access_scheduler;

    localparam int NR    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [NR*DW-1:0]  req_data = '0;
    logic [NR-1:0]     req_ready;
    logic              rd_req = 1'b0;
    logic              rd_valid;
    logic [DW-1:0]     rd_data;
    logic              fifo_wr;
    logic              fifo_rd;
    logic [DW-1:0]     fifo_din;
    logic [DW-1:0]     fifo_dout;
    logic              fifo_empty;
    logic              fifo_full;
    logic [1:0]        grant_id;
    logic [4:0]        occupancy;
`ifdef FIFO_SCHED_WATERMARK_EN
    logic              almost_full;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fifo_access_scheduler #(.NUM_REQ(NR), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .rd_req     (rd_req),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .fifo_wr    (fifo_wr),
        .fifo_rd    (fifo_rd),
        .fifo_din   (fifo_din),
        .fifo_dout  (fifo_dout),
        .fifo_empty (fifo_empty),
        .fifo_full  (fifo_full),
        .grant_id   (grant_id),
        .occupancy  (occupancy)
`ifdef FIFO_SCHED_WATERMARK_EN
        ,
        .almost_full(almost_full)
`endif
    );

    // Behavioural FIFO: one op per clock, write has priority, registered dout.
    logic [DW-1:0] mem [DEPTH];
    logic [3:0]    wp, rp;
    logic [4:0]    cnt;
    assign fifo_empty = (cnt == 0);
    assign fifo_full  = (cnt == 5'(DEPTH));
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            wp <= '0; rp <= '0; cnt <= '0; fifo_dout <= '0;
        end else if (fifo_wr && !fifo_full) begin
            mem[wp] <= fifo_din; wp <= wp + 4'd1; cnt <= cnt + 5'd1;
        end else if (fifo_rd && !fifo_empty) begin
            fifo_dout <= mem[rp]; rp <= rp + 4'd1; cnt <= cnt - 5'd1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req_valid = '0; rd_req = 1'b0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        req_valid = 4'hF; rd_req = 1'b1; req_data = 32'h4433_2211;
        #1;
        n_checks++; if (fifo_wr !== 1'b0) $display("FAIL rst_wr: got %b exp 0", fifo_wr); else n_pass++;
        n_checks++; if (fifo_rd !== 1'b0) $display("FAIL rst_rd: got %b exp 0", fifo_rd); else n_pass++;
        n_checks++; if (req_ready !== 4'b0000) $display("FAIL rst_ready: got %b exp 0000", req_ready); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (occupancy !== 5'd0) $display("FAIL rst_occ: got %0d exp 0", occupancy); else n_pass++;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL rst_rdv: got %b exp 0", rd_valid); else n_pass++;
        @(negedge clk);
        rst = 1'b1; req_valid = '0; rd_req = 1'b0;
    endtask

    task automatic test_rr_fill();
        logic [1:0]    exp_gid;
        logic [DW-1:0] exp_din;
        do_reset();
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            req_valid = 4'hF; rd_req = 1'b0;
            exp_gid = 2'(i % 4);
            exp_din = 8'hA0 + 8'(i % 4);
            #1;
            n_checks++; if (grant_id !== exp_gid) $display("FAIL rr_gid[%0d]: got %0d exp %0d", i, grant_id, exp_gid); else n_pass++;
            n_checks++; if (req_ready !== (4'b0001 << (i % 4))) $display("FAIL rr_ready[%0d]: got %b exp %b", i, req_ready, 4'b0001 << (i % 4)); else n_pass++;
            n_checks++; if (fifo_din !== exp_din) $display("FAIL rr_din[%0d]: got %h exp %h", i, fifo_din, exp_din); else n_pass++;
            @(posedge clk); #1;
            n_checks++; if (occupancy !== 5'(i + 1)) $display("FAIL rr_occ[%0d]: got %0d exp %0d", i, occupancy, i + 1); else n_pass++;
        end
        @(negedge clk); #1;
        n_checks++; if (fifo_full !== 1'b1) $display("FAIL full_flag: got %b exp 1", fifo_full); else n_pass++;
        n_checks++; if (req_ready !== 4'b0000) $display("FAIL full_ready: got %b exp 0000", req_ready); else n_pass++;
        n_checks++; if (fifo_wr !== 1'b0) $display("FAIL full_wr: got %b exp 0", fifo_wr); else n_pass++;
        n_checks++; if (occupancy !== 5'd16) $display("FAIL full_occ: got %0d exp 16", occupancy); else n_pass++;
        req_valid = '0;
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            req_valid = 4'b0010; rd_req = 1'b0;
            req_data = {8'hEE, 8'hEE, 8'h10 + 8'(i), 8'hEE};
            #1;
            n_checks++; if (grant_id !== 2'd1) $display("FAIL single_gid[%0d]: got %0d exp 1", i, grant_id); else n_pass++;
            n_checks++; if (fifo_din !== 8'h10 + 8'(i)) $display("FAIL single_din[%0d]: got %h exp %h", i, fifo_din, 8'h10 + 8'(i)); else n_pass++;
        end
        @(negedge clk);
        req_valid = '0; rd_req = 1'b1;
        #1;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL drain_first_rdv: got %b exp 0", rd_valid); else n_pass++;
        for (int k = 0; k < 16; k++) begin
            n_checks++; if (fifo_rd !== 1'b1) $display("FAIL drain_rd[%0d]: got %b exp 1", k, fifo_rd); else n_pass++;
            @(posedge clk); #1;
            n_checks++; if (rd_valid !== 1'b1) $display("FAIL drain_rdv[%0d]: got %b exp 1", k, rd_valid); else n_pass++;
            n_checks++; if (rd_data !== 8'h10 + 8'(k)) $display("FAIL drain_data[%0d]: got %h exp %h", k, rd_data, 8'h10 + 8'(k)); else n_pass++;
            @(negedge clk); #1;
        end
        n_checks++; if (occupancy !== 5'd0) $display("FAIL drain_occ: got %0d exp 0", occupancy); else n_pass++;
        n_checks++; if (fifo_rd !== 1'b0) $display("FAIL drain_empty_rd: got %b exp 0", fifo_rd); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL drain_end_rdv: got %b exp 0", rd_valid); else n_pass++;
        @(negedge clk);
        rd_req = 1'b0;
    endtask

    task automatic test_alternate();
        logic exp_wr;
        do_reset();
        req_data = {8'h00, 8'h5A, 8'h00, 8'h00};
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            req_valid = 4'b0100; rd_req = 1'b0;
        end
        @(negedge clk);
        req_valid = '0; rd_req = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            req_valid = 4'b0100; rd_req = 1'b1;
            exp_wr = ((c % 2) == 0);
            #1;
            n_checks++; if (fifo_wr !== exp_wr) $display("FAIL alt_wr[%0d]: got %b exp %b", c, fifo_wr, exp_wr); else n_pass++;
            n_checks++; if (fifo_rd !== !exp_wr) $display("FAIL alt_rd[%0d]: got %b exp %b", c, fifo_rd, !exp_wr); else n_pass++;
            @(posedge clk); #1;
            n_checks++; if (occupancy !== (exp_wr ? 5'd9 : 5'd8)) $display("FAIL alt_occ[%0d]: got %0d exp %0d", c, occupancy, exp_wr ? 9 : 8); else n_pass++;
        end
        @(negedge clk);
        req_valid = '0; rd_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        req_data = {8'h33, 8'h22, 8'h11, 8'h00};
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            req_valid = 4'b0010; rd_req = 1'b0;
        end
        @(negedge clk);
        req_valid = 4'hF; rd_req = 1'b1;
        #1;
        n_checks++; if (fifo_rd !== 1'b1) $display("FAIL mid_pre_rd: got %b exp 1", fifo_rd); else n_pass++;
        rst = 1'b0;
        #1;
        n_checks++; if (fifo_wr !== 1'b0) $display("FAIL mid_wr: got %b exp 0", fifo_wr); else n_pass++;
        n_checks++; if (fifo_rd !== 1'b0) $display("FAIL mid_rd: got %b exp 0", fifo_rd); else n_pass++;
        n_checks++; if (req_ready !== 4'b0000) $display("FAIL mid_ready: got %b exp 0000", req_ready); else n_pass++;
        n_checks++; if (occupancy !== 5'd0) $display("FAIL mid_occ: got %0d exp 0", occupancy); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (rd_valid !== 1'b0) $display("FAIL post_rdv: got %b exp 0", rd_valid); else n_pass++;
        n_checks++; if (grant_id !== 2'd0) $display("FAIL post_gid: got %0d exp 0", grant_id); else n_pass++;
        n_checks++; if (req_ready !== 4'b0001) $display("FAIL post_ready: got %b exp 0001", req_ready); else n_pass++;
        @(posedge clk); #1;
        n_checks++; if (occupancy !== 5'd1) $display("FAIL post_occ: got %0d exp 1", occupancy); else n_pass++;
        @(negedge clk);
        req_valid = '0; rd_req = 1'b0;
    endtask

    task automatic test_empty_read();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_valid = '0; rd_req = 1'b1;
            #1;
            n_checks++; if (fifo_rd !== 1'b0) $display("FAIL empty_rd[%0d]: got %b exp 0", c, fifo_rd); else n_pass++;
            @(posedge clk); #1;
            n_checks++; if (rd_valid !== 1'b0) $display("FAIL empty_rdv[%0d]: got %b exp 0", c, rd_valid); else n_pass++;
        end
        @(negedge clk);
        rd_req = 1'b0;
    endtask

`ifdef FIFO_SCHED_WATERMARK_EN
    task automatic test_watermark();
        logic exp_rd;
        do_reset();
        req_data = {8'h00, 8'h00, 8'h00, 8'h77};
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            req_valid = 4'b0001; rd_req = 1'b0;
        end
        @(negedge clk);
        req_valid = '0; rd_req = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            req_valid = 4'b0001; rd_req = 1'b1;
            exp_rd = ((c % 2) == 0);
            #1;
            n_checks++; if (almost_full !== exp_rd) $display("FAIL wm_af[%0d]: got %b exp %b", c, almost_full, exp_rd); else n_pass++;
            n_checks++; if (fifo_rd !== exp_rd) $display("FAIL wm_rd[%0d]: got %b exp %b", c, fifo_rd, exp_rd); else n_pass++;
            @(posedge clk); #1;
            n_checks++; if (occupancy !== (exp_rd ? 5'd11 : 5'd12)) $display("FAIL wm_occ[%0d]: got %0d exp %0d", c, occupancy, exp_rd ? 11 : 12); else n_pass++;
        end
        @(negedge clk);
        req_valid = '0; rd_req = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_rr_fill();
        test_fill_drain();
        test_alternate();
        test_reset_mid();
        test_empty_read();
`ifdef FIFO_SCHED_WATERMARK_EN
        test_watermark();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
